// File: rtl/alu4_count_decode_pkg.sv
// Shared constants for alu4_count_decode: ALU opcodes and the default counter width.
package alu4_count_decode_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    localparam int unsigned CNT_W_DEFAULT = 3;

endpackage

// File: rtl/alu4_core.sv
// 4-bit combinational ALU with zero, signed-overflow and carry flags.
module alu4_core
    import alu4_count_decode_pkg::*;
(
    input  logic [2:0] fnselec,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] res,
    output logic       zero,
    output logic       overflow,
    output logic       carry
);

    logic [4:0] sum;
    logic [4:0] diff;

    // SUB uses a + ~b + 1 so carry means "no borrow".
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + 5'd1;

    always_comb begin
        res      = 4'h0;
        overflow = 1'b0;
        carry    = 1'b0;
        unique case (fnselec)
            ALU_ADD: begin
                res      = sum[3:0];
                carry    = sum[4];
                overflow = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            ALU_SUB: begin
                res      = diff[3:0];
                carry    = diff[4];
                overflow = (a[3] != b[3]) && (diff[3] != a[3]);
            end
            ALU_NOT: res = ~a;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLT: res = {3'b000, ($signed(a) < $signed(b))};
            ALU_EQ:  res = {3'b000, (a == b)};
            default: res = 4'h0;
        endcase
    end

    assign zero = (res == 4'h0);

endmodule

// File: rtl/alu4_count_decode.sv
// Board helper block: 4-bit ALU, 3-to-8 one-hot decoder and a tick-driven down counter.
module alu4_count_decode
    import alu4_count_decode_pkg::*;
#(
    parameter int unsigned          CNT_W    = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0]     CNT_INIT = '1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       alu_fnselec,
    input  logic [3:0]       alu_a,
    input  logic [3:0]       alu_b,
    output logic [3:0]       alu_res,
    output logic             alu_zero,
    output logic             alu_overflow,
    output logic             alu_carry,
    input  logic [2:0]       dec_x,
    input  logic             dec_en,
    output logic [7:0]       dec_y,
    input  logic             cnt_tick,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt_q
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d;

    alu4_core u_alu4_core (
        .fnselec  (alu_fnselec),
        .a        (alu_a),
        .b        (alu_b),
        .res      (alu_res),
        .zero     (alu_zero),
        .overflow (alu_overflow),
        .carry    (alu_carry)
    );

    assign dec_y = dec_en ? (8'h01 << dec_x) : 8'h00;

    // Wrap to CNT_INIT rather than all ones so a non-default init still cycles correctly.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_en && cnt_tick) begin
            cnt_d = (cnt_q == '0) ? CNT_INIT : (cnt_q - CntOne);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= CNT_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu4_count_decode.sv
// Directed self-checking bench for alu4_count_decode.
module tb_alu4_count_decode;

    logic       clk;
    logic       resetn;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic [2:0] dec_x;
    logic       dec_en;
    logic [7:0] dec_y;
    logic       cnt_tick;
    logic       cnt_en;
    logic [2:0] cnt_q;

    int checks = 0;
    int errors = 0;

    alu4_count_decode #(
        .CNT_W    (3),
        .CNT_INIT (3'd7)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alu_fnselec  (alu_fnselec),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_res      (alu_res),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .dec_x        (dec_x),
        .dec_en       (dec_en),
        .dec_y        (dec_y),
        .cnt_tick     (cnt_tick),
        .cnt_en       (cnt_en),
        .cnt_q        (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] res, input logic z,
                           input logic ov, input logic c);
        alu_fnselec = op;
        alu_a       = a;
        alu_b       = b;
        #1;
        chk({tag, ".res"}, {28'd0, alu_res}, {28'd0, res});
        chk({tag, ".zero"}, {31'd0, alu_zero}, {31'd0, z});
        chk({tag, ".ovf"}, {31'd0, alu_overflow}, {31'd0, ov});
        chk({tag, ".carry"}, {31'd0, alu_carry}, {31'd0, c});
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_y;
        logic [2:0] exp_cnt;

        resetn      = 1'b0;
        alu_fnselec = 3'b000;
        alu_a       = 4'h0;
        alu_b       = 4'h0;
        dec_x       = 3'd0;
        dec_en      = 1'b0;
        cnt_tick    = 1'b0;
        cnt_en      = 1'b0;

        step();
        chk("reset.cnt", {29'd0, cnt_q}, 32'd7);

        // ALU vectors, evaluated while reset is still asserted.
        alu_vec("add_ovf",   3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
        alu_vec("add_carry", 3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
        alu_vec("sub_borrow", 3'b001, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
        alu_vec("sub_eq",    3'b001, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1);
        alu_vec("sub_ovf",   3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1);
        alu_vec("not",       3'b010, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0);
        alu_vec("and",       3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
        alu_vec("or",        3'b100, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0);
        alu_vec("xor",       3'b101, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0);
        alu_vec("slt_true",  3'b110, 4'h8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0);
        alu_vec("slt_false", 3'b110, 4'h7, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0);
        alu_vec("eq_true",   3'b111, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0);
        alu_vec("eq_false",  3'b111, 4'h5, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0);

        // Decoder sweep.
        dec_en = 1'b1;
        exp_y  = 8'h01;
        for (int i = 0; i < 8; i++) begin
            dec_x = 3'(i);
            #1;
            chk($sformatf("dec_y[%0d]", i), {24'd0, dec_y}, {24'd0, exp_y});
            exp_y = {exp_y[6:0], 1'b0};
        end
        dec_en = 1'b0;
        dec_x  = 3'd5;
        #1;
        chk("dec_disabled", {24'd0, dec_y}, 32'd0);

        // Eight single-cycle ticks: 6,5,...,0 then wrap to 7.
        resetn  = 1'b1;
        cnt_en  = 1'b1;
        exp_cnt = 3'd6;
        for (int i = 0; i < 8; i++) begin
            cnt_tick = 1'b1;
            step();
            cnt_tick = 1'b0;
            chk($sformatf("cnt_tick%0d", i), {29'd0, cnt_q}, {29'd0, exp_cnt});
            step();
            chk($sformatf("cnt_idle%0d", i), {29'd0, cnt_q}, {29'd0, exp_cnt});
            exp_cnt = (i == 6) ? 3'd7 : exp_cnt - 3'd1;
        end

        // Ticks without enable must not change the count.
        cnt_en   = 1'b0;
        cnt_tick = 1'b1;
        repeat (3) step();
        chk("cnt_hold", {29'd0, cnt_q}, 32'd7);

        // Tick held four cycles decrements four times: 7 -> 3.
        cnt_en = 1'b1;
        repeat (4) step();
        chk("cnt_held_tick", {29'd0, cnt_q}, 32'd3);

        // Reset coinciding with a tick wins.
        resetn = 1'b0;
        step();
        chk("cnt_reset_mid", {29'd0, cnt_q}, 32'd7);
        resetn   = 1'b1;
        cnt_tick = 1'b0;
        step();
        chk("cnt_after_reset", {29'd0, cnt_q}, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu4_count_decode.md
# alu4_count_decode

Small combinational/sequential utility block grouping three board-level helpers: a 4-bit ALU with flags, a 3-to-8 one-hot decoder with enable, and an enable-gated down counter. It sits beside the seven-segment and LED logic in the top-level board design. It drives status and indicator outputs from switches and a slow timer tick. Only the counter holds state; the ALU and decoder are purely combinational.

## Interface
Parameters:
- CNT_W, 3, down-counter width in bits.
- CNT_INIT, all ones (7 for CNT_W=3), counter value loaded on reset and on wrap.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- alu_fnselec  in  3  ALU operation select.
- alu_a  in  4  operand A, two's complement.
- alu_b  in  4  operand B, two's complement.
- alu_res  out  4  ALU result.
- alu_zero  out  1  high when alu_res == 0.
- alu_overflow  out  1  signed overflow (add/sub only).
- alu_carry  out  1  carry-out (add/sub only).
- dec_x  in  3  decoder select.
- dec_en  in  1  decoder enable.
- dec_y  out  8  one-hot decoder output.
- cnt_tick  in  1  single-cycle count strobe, e.g. the 1 s timer pulse.
- cnt_en  in  1  counter enable.
- cnt_q  out  CNT_W  counter value.

## Operation
ALU operation codes, all results 4 bits:
- 000 ADD: {carry,res} = a + b.
  - overflow = (a[3]==b[3]) && (res[3]!=a[3]).
- 001 SUB: {carry,res} = a + ~b + 1.
  - carry = 1 means no borrow, i.e. a >= b unsigned.
  - overflow = (a[3]!=b[3]) && (res[3]!=a[3]).
- 010 NOT: res = ~a.
- 011 AND: res = a & b.
- 100 OR: res = a | b.
- 101 XOR: res = a ^ b.
- 110 SLT: res = {3'b000, signed(a) < signed(b)}.
- 111 EQ: res = {3'b000, a == b}.
- For opcodes 010–111, carry = 0 and overflow = 0.
- alu_zero is derived from alu_res for every opcode.

Decoder:
- dec_en = 1: dec_y = 1 << dec_x.
- dec_en = 0: dec_y = 8'h00.

Counter:
- On a clock edge with resetn = 0: cnt_q <= CNT_INIT. Reset has priority over everything else.
- Otherwise, if cnt_en && cnt_tick: cnt_q <= cnt_q − 1; from 0 it wraps to CNT_INIT.
- Otherwise cnt_q holds.
- cnt_tick high with cnt_en low does not change cnt_q.

## Timing
- ALU and decoder: zero latency, purely combinational, unaffected by resetn.
- Counter: updates one clk edge after a qualified tick. A tick held high for N cycles with cnt_en high decrements N times.
- Reset value: cnt_q = CNT_INIT. All other outputs follow their inputs immediately during reset.
- Reset asserted mid-count: cnt_q returns to CNT_INIT at the next edge, even if a tick coincides with it.
- No handshakes; inputs are sampled or evaluated directly.

## Structure
- Shared package: ALU opcode constants (ALU_ADD … ALU_EQ, 3 bits) and the default CNT_W.
- One natural sub-module: alu4_core, holding the ALU and flag logic.
- Decoder and counter stay inline in alu4_count_decode.

## Test plan
- ADD a=4'h7, b=4'h1 → res=4'h8, overflow=1, carry=0, zero=0. ADD a=4'hF, b=4'h1 → res=0, carry=1, overflow=0, zero=1.
- SUB a=4'h0, b=4'h1 → res=4'hF, carry=0, overflow=0. SUB a=4'h4, b=4'h4 → res=0, zero=1, carry=1. SUB a=4'h8, b=4'h1 → res=4'h7, overflow=1.
- Logic/compare with a=4'hC, b=4'hA:
  - NOT → 4'h3; AND → 4'h8; OR → 4'hE; XOR → 4'h6 (carry=overflow=0 throughout).
  - SLT a=4'h8, b=4'h7 → 1; EQ a=b=4'h5 → 1.
- Decoder: dec_en=1 sweeping dec_x 0..7 → dec_y 01,02,04,…,80. dec_en=0 with dec_x=5 → 00.
- Counter sequence:
  - resetn low one edge → cnt_q=7.
  - 8 single-cycle ticks with cnt_en=1 → 6,5,4,3,2,1,0,7.
  - cnt_en=0 with ticks → value holds.
- Counter reset mid-count: from cnt_q=3, assert resetn=0 on the same edge as a tick → cnt_q=7.
